// File: rtl/c880_bist_pkg.sv
// c880 BIST shared definitions.
// Widths, LFSR/MISR taps, FSM states and next-value helpers.
package c880_bist_pkg;

    localparam int PI_W   = 60;
    localparam int PO_W   = 26;
    localparam int MISR_W = 32;

    // x^60 + x^59 + 1: feedback from bits 59 and 58
    localparam logic [PI_W-1:0]   LFSR_TAPS = 60'hC00_0000_0000_0000;
    // feedback from bits 31, 21, 1 and 0
    localparam logic [MISR_W-1:0] MISR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        RUN,
        DRAIN,
        COMPARE,
        DONE
    } bist_state_t;

    function automatic logic [PI_W-1:0] lfsr_next(
        input logic [PI_W-1:0] cur
    );
        return {cur[PI_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] cur,
        input logic [PO_W-1:0]   data
    );
        return {cur[MISR_W-2:0], ^(cur & MISR_TAPS)}
             ^ {{(MISR_W-PO_W){1'b0}}, data};
    endfunction

endpackage

// File: rtl/c880_bist_if.sv
// c880 BIST bus: config/status plus the c880 pin interface.
// slave = BIST controller, master = surrounding test logic and c880.
interface c880_bist_if;
    import c880_bist_pkg::*;

    logic              start;
    logic [MISR_W-1:0] golden_sig;
    logic [PI_W-1:0]   dut_pi;
    logic [PO_W-1:0]   dut_po;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;

    modport master (
        output start, golden_sig, dut_po,
        input  dut_pi, busy, done, pass, signature
    );

    modport slave (
        input  start, golden_sig, dut_po,
        output dut_pi, busy, done, pass, signature
    );

endinterface

// File: rtl/c880_bist_misr.sv
// 32-bit multiple-input signature register.
// Clear has priority over compaction.
module c880_bist_misr
    import c880_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [PO_W-1:0]   data,
    output logic [MISR_W-1:0] sig
);

    // Signature register: clear on a new run, compact when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, data);
        end
    end

endmodule

// File: rtl/c880_bist_ctrl.sv
// BIST controller for one c880 instance.
// LFSR patterns out, MISR-compacted responses in, golden compare.
module c880_bist_ctrl
    import c880_bist_pkg::PI_W,
           c880_bist_pkg::MISR_W,
           c880_bist_pkg::bist_state_t,
           c880_bist_pkg::IDLE,
           c880_bist_pkg::RUN,
           c880_bist_pkg::DRAIN,
           c880_bist_pkg::COMPARE,
           c880_bist_pkg::DONE,
           c880_bist_pkg::lfsr_next;
#(
    parameter int              NUM_PAT  = 1024,
    parameter int              PIPE_LAT = 0,
    parameter logic [PI_W-1:0] SEED     = 60'h1
) (
    input logic        clk,
    input logic        rst_n,
    c880_bist_if.slave bus
);

    localparam logic [15:0] LAST_PAT = 16'(NUM_PAT - 1);
    localparam logic [16:0] LAT_EXT  = 17'(PIPE_LAT);
    localparam logic [1:0]  LAT_LAST = 2'(PIPE_LAT - 1);

    bist_state_t       state;
    bist_state_t       state_nx;
    logic [PI_W-1:0]   lfsr;
    logic [15:0]       pat_cnt;
    logic [1:0]        lat_cnt;
    logic              pass_q;
    logic [MISR_W-1:0] misr;

    logic load_seed;
    logic lfsr_adv;
    logic cnt_en;
    logic lat_en;
    logic misr_en;
    logic do_cmp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nx  = state;
        load_seed = 1'b0;
        lfsr_adv  = 1'b0;
        cnt_en    = 1'b0;
        lat_en    = 1'b0;
        misr_en   = 1'b0;
        do_cmp    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx  = c880_bist_pkg::SEED;
                    load_seed = 1'b1;
                end
            end
            c880_bist_pkg::SEED: begin
                state_nx = RUN;
            end
            RUN: begin
                cnt_en  = 1'b1;
                // pat_cnt >= PIPE_LAT: response of pattern 0 has arrived
                misr_en = ({1'b0, pat_cnt} + 17'd1) > LAT_EXT;
                if (pat_cnt == LAST_PAT) begin
                    state_nx = (PIPE_LAT > 0) ? DRAIN : COMPARE;
                end else begin
                    lfsr_adv = 1'b1;
                end
            end
            DRAIN: begin
                misr_en = 1'b1;
                lat_en  = 1'b1;
                if (lat_cnt == LAT_LAST) begin
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                do_cmp   = 1'b1;
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pattern generator, counters and verdict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr    <= '0;
            pat_cnt <= '0;
            lat_cnt <= '0;
            pass_q  <= 1'b0;
        end else begin
            if (load_seed) begin
                lfsr <= SEED;
            end else if (lfsr_adv) begin
                lfsr <= lfsr_next(lfsr);
            end
            if (load_seed) begin
                pat_cnt <= '0;
            end else if (cnt_en) begin
                pat_cnt <= pat_cnt + 16'd1;
            end
            if (load_seed) begin
                lat_cnt <= '0;
            end else if (lat_en) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            if (load_seed) begin
                pass_q <= 1'b0;
            end else if (do_cmp) begin
                pass_q <= (misr == bus.golden_sig);
            end
        end
    end

    c880_bist_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load_seed),
        .en    (misr_en),
        .data  (bus.dut_po),
        .sig   (misr)
    );

    assign bus.dut_pi    = lfsr;
    assign bus.signature = misr;
    assign bus.pass      = pass_q;
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state == c880_bist_pkg::SEED)
                        || (state == RUN)
                        || (state == DRAIN)
                        || (state == COMPARE);

endmodule
